// File: rtl/muldiv_seq_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_seq_ctrl_pkg
//   Shared types and constants for the RV32M multiply/divide sequencer.
//   - m_func_t       : M-extension function code (instr[14:12])
//   - muldiv_state_t : sequencer FSM states
//   - DIV_ZERO_Q     : quotient returned for divide-by-zero
//   - INT_MIN        : most negative 32-bit value (signed overflow case)
//   - mag()          : magnitude of an operand, optionally treating it as signed
// -----------------------------------------------------------------------------
package muldiv_seq_ctrl_pkg;

   typedef enum logic [2:0] {
      M_MUL    = 3'd0,
      M_MULH   = 3'd1,
      M_MULHSU = 3'd2,
      M_MULHU  = 3'd3,
      M_DIV    = 3'd4,
      M_DIVU   = 3'd5,
      M_REM    = 3'd6,
      M_REMU   = 3'd7
   } m_func_t;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      MUL  = 3'd1,
      DIV  = 3'd2,
      FIX  = 3'd3,
      DONE = 3'd4
   } muldiv_state_t;

   localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
   localparam logic [31:0] INT_MIN    = 32'h8000_0000;

   // Two's-complement magnitude when the operand is treated as signed and is
   // negative. INT_MIN maps to 32'h8000_0000, which is correct as unsigned.
   function automatic logic [31:0] mag(input logic [31:0] v, input logic is_signed);
      return (is_signed && v[31]) ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// -----------------------------------------------------------------------------
// muldiv_div_core
//   Iterative restoring unsigned divider, one quotient bit per cycle, MSB first.
//   start loads the operands; W cycles later quotient/remainder are final.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   start      : load dividend/divisor and begin iterating
//   abort      : drop any division in progress
//   dividend   : unsigned dividend
//   divisor    : unsigned divisor (nonzero; zero is handled by the caller)
//   quotient   : quotient, final once done has been seen
//   remainder  : remainder, final once done has been seen
//   done       : high during the cycle whose edge performs the last iteration
// -----------------------------------------------------------------------------
module muldiv_div_core #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         abort,
   input  logic [W-1:0] dividend,
   input  logic [W-1:0] divisor,
   output logic [W-1:0] quotient,
   output logic [W-1:0] remainder,
   output logic         done
);

   localparam int CW = $clog2(W);
   localparam logic [CW-1:0] LAST = CW'(W - 1);

   logic          running;
   logic [CW-1:0] cnt;
   logic [W-1:0]  q_reg;
   logic [W-1:0]  r_reg;
   logic [W-1:0]  d_reg;

   // The shifted partial remainder needs W+1 bits; the top bit of the trial
   // subtraction is the borrow (shifted < 2*divisor keeps this exact).
   logic [W:0]    shifted;
   logic [W:0]    trial;

   always_comb begin
      shifted = {r_reg, q_reg[W-1]};
      trial   = shifted - {1'b0, d_reg};
   end

   assign done      = running && (cnt == LAST);
   assign quotient  = q_reg;
   assign remainder = r_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         running <= 1'b0;
         cnt     <= '0;
         q_reg   <= '0;
         r_reg   <= '0;
         d_reg   <= '0;
      end else if (abort) begin
         running <= 1'b0;
         cnt     <= '0;
      end else if (start) begin
         running <= 1'b1;
         cnt     <= '0;
         q_reg   <= dividend;
         r_reg   <= '0;
         d_reg   <= divisor;
      end else if (running) begin
         if (!trial[W]) begin
            r_reg <= trial[W-1:0];
            q_reg <= {q_reg[W-2:0], 1'b1};
         end else begin
            r_reg <= shifted[W-1:0];
            q_reg <= {q_reg[W-2:0], 1'b0};
         end
         if (cnt == LAST) begin
            running <= 1'b0;
            cnt     <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/muldiv_seq_ctrl.sv
// -----------------------------------------------------------------------------
// muldiv_seq_ctrl
//   Multi-cycle sequencer for the RV32M MULDIV unit. Accepts one op at a time,
//   multiplies in MUL_LAT cycles, divides with a 32-step restoring iteration,
//   and holds the result until the consumer takes it.
//   Handshake: a transfer happens on a rising edge where valid && ready. Once
//   raised, resp_valid and resp_data stay unchanged until resp_ready, except
//   when flush or rst kills the op.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   flush       : abort any in-flight op, drop its result
//   req_valid/req_ready, req_func, req_rs1, req_rs2 : op request
//   resp_valid/resp_ready, resp_data                 : result
//   busy        : unit not idle (execute-stage stall)
// -----------------------------------------------------------------------------
module muldiv_seq_ctrl
   import muldiv_seq_ctrl_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int MUL_LAT = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [2:0]      req_func,
   input  logic [XLEN-1:0] req_rs1,
   input  logic [XLEN-1:0] req_rs2,
   output logic            resp_valid,
   input  logic            resp_ready,
   output logic [XLEN-1:0] resp_data,
   output logic            busy
);

   localparam logic [1:0] MUL_LAST = 2'(MUL_LAT - 1);

   muldiv_state_t   state, state_d;
   logic [1:0]      mul_cnt, mul_cnt_d;
   m_func_t         func_q;
   logic [XLEN-1:0] rs1_q, rs2_q;
   logic            neg_q_q, neg_r_q;

   logic            accept;
   m_func_t         func_in;
   logic            req_signed_div, req_div_zero, req_ovf, req_special;
   logic [XLEN-1:0] special_res;
   logic            data_load;
   logic [XLEN-1:0] data_d;
   logic            div_start, div_done;
   logic [XLEN-1:0] div_quot, div_rem;
   logic [63:0]     op_a, op_b, prod;
   logic [XLEN-1:0] mul_res, div_res;

   assign req_ready  = (state == IDLE) && !rst && !flush;
   assign accept     = req_valid && req_ready;
   assign resp_valid = (state == DONE);
   assign busy       = (state != IDLE);

   // Request decode; special divide cases are resolved at accept time.
   always_comb begin
      func_in        = m_func_t'(req_func);
      req_signed_div = (func_in == M_DIV) || (func_in == M_REM);
      req_div_zero   = (req_rs2 == '0);
      req_ovf        = req_signed_div && (req_rs1 == INT_MIN) && (req_rs2 == '1);
      req_special    = req_func[2] && (req_div_zero || req_ovf);
      if (req_func[1]) special_res = req_div_zero ? req_rs1 : '0;         // REM/REMU
      else             special_res = req_div_zero ? DIV_ZERO_Q : INT_MIN; // DIV/DIVU
   end

   // Multiply: extend each operand to 64 bits by its signedness; the low 64
   // bits of the product are then correct for every M-ext multiply.
   always_comb begin
      op_a = ((func_q == M_MULH) || (func_q == M_MULHSU)) ? {{32{rs1_q[31]}}, rs1_q}
                                                          : {32'b0, rs1_q};
      op_b = (func_q == M_MULH) ? {{32{rs2_q[31]}}, rs2_q} : {32'b0, rs2_q};
      prod = op_a * op_b;
      mul_res = (func_q == M_MUL) ? prod[31:0] : prod[63:32];
   end

   // Sign fixup of the unsigned division result.
   always_comb begin
      if (func_q == M_REM || func_q == M_REMU) div_res = neg_r_q ? (~div_rem + 32'd1) : div_rem;
      else                                     div_res = neg_q_q ? (~div_quot + 32'd1) : div_quot;
   end

   muldiv_div_core #(.W(XLEN)) u_div (
      .clk       (clk),
      .rst       (rst),
      .start     (div_start),
      .abort     (flush),
      .dividend  (mag(req_rs1, req_signed_div)),
      .divisor   (mag(req_rs2, req_signed_div)),
      .quotient  (div_quot),
      .remainder (div_rem),
      .done      (div_done)
   );

   // Next-state and load controls.
   always_comb begin
      state_d   = state;
      mul_cnt_d = mul_cnt;
      data_load = 1'b0;
      data_d    = resp_data;
      div_start = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               if (!req_func[2]) begin
                  state_d   = MUL;
                  mul_cnt_d = '0;
               end else if (req_special) begin
                  state_d   = DONE;
                  data_load = 1'b1;
                  data_d    = special_res;
               end else begin
                  state_d   = DIV;
                  div_start = 1'b1;
               end
            end
         end
         MUL: begin
            if (mul_cnt == MUL_LAST) begin
               state_d   = DONE;
               data_load = 1'b1;
               data_d    = mul_res;
            end else begin
               mul_cnt_d = mul_cnt + 2'd1;
            end
         end
         DIV: begin
            if (div_done) state_d = FIX;
         end
         FIX: begin
            state_d   = DONE;
            data_load = 1'b1;
            data_d    = div_res;
         end
         DONE: begin
            if (resp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // A flush kills whatever is in flight; a DONE result is simply dropped.
      if (flush) begin
         state_d   = IDLE;
         data_load = 1'b0;
         div_start = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         mul_cnt   <= '0;
         resp_data <= '0;
         func_q    <= M_MUL;
         rs1_q     <= '0;
         rs2_q     <= '0;
         neg_q_q   <= 1'b0;
         neg_r_q   <= 1'b0;
      end else begin
         state   <= state_d;
         mul_cnt <= mul_cnt_d;
         if (data_load) resp_data <= data_d;
         if (accept) begin
            func_q  <= func_in;
            rs1_q   <= req_rs1;
            rs2_q   <= req_rs2;
            neg_q_q <= req_signed_div && (req_rs1[31] ^ req_rs2[31]);
            neg_r_q <= req_signed_div && req_rs1[31];
         end
      end
   end

endmodule

// File: tb/tb_muldiv_seq_ctrl.sv
module tb_muldiv_seq_ctrl;
   import muldiv_seq_ctrl_pkg::*;

   localparam int MUL_LAT = 1;
   localparam int DIV_LAT = 33;

   // ---------------- clock / reset ----------------
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [2:0]  req_func = 3'd0;
   logic [31:0] req_rs1 = '0;
   logic [31:0] req_rs2 = '0;
   logic        resp_valid;
   logic        resp_ready = 1'b0;
   logic [31:0] resp_data;
   logic        busy;

   always #5 clk = ~clk;

   muldiv_seq_ctrl #(.XLEN(32), .MUL_LAT(MUL_LAT)) dut (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_func   (req_func),
      .req_rs1    (req_rs1),
      .req_rs2    (req_rs2),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_data  (resp_data),
      .busy       (busy)
   );

   // ---------------- scoreboard ----------------
   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] exp_q[$];

   typedef struct {
      logic [2:0]  func;
      logic [31:0] rs1;
      logic [31:0] rs2;
      logic [31:0] exp;
      int          lat;
      string       name;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic void add_vec(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] e, input int l, input string n);
      vec_t v;
      v.func = f; v.rs1 = a; v.rs2 = b; v.exp = e; v.lat = l; v.name = n;
      vecs.push_back(v);
   endfunction

   // Independent reference: 64-bit integer arithmetic.
   function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      longint          sa, sb, sbu, sp;
      longint unsigned ua, ub, up;
      logic [63:0]     t;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      sbu = {32'b0, b};
      ua = {32'b0, a};
      ub = {32'b0, b};
      case (f)
         3'd0: begin up = ua * ub;  t = up; return t[31:0];  end
         3'd1: begin sp = sa * sb;  t = sp; return t[63:32]; end
         3'd2: begin sp = sa * sbu; t = sp; return t[63:32]; end
         3'd3: begin up = ua * ub;  t = up; return t[63:32]; end
         3'd4: begin if (b == 0) return 32'hFFFF_FFFF; sp = sa / sb; t = sp; return t[31:0]; end
         3'd5: begin if (b == 0) return 32'hFFFF_FFFF; up = ua / ub; t = up; return t[31:0]; end
         3'd6: begin if (b == 0) return a; sp = sa % sb; t = sp; return t[31:0]; end
         default: begin if (b == 0) return a; up = ua % ub; t = up; return t[31:0]; end
      endcase
   endfunction

   function automatic int model_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      if (!f[2]) return MUL_LAT;
      if (b == 0) return 0;
      if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
      return DIV_LAT;
   endfunction

   // ---------------- driver tasks ----------------
   // Drive a request at the negedge; return just after the accepting edge.
   task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] e, input string name);
      @(negedge clk);
      req_func = f; req_rs1 = a; req_rs2 = b; req_valid = 1'b1;
      #1 check({name, " req_ready"}, 32'(req_ready), 32'd1);
      @(posedge clk);
      exp_q.push_back(e);
      #1 req_valid = 1'b0;
   endtask

   // Count edges from accept until resp_valid, compare, then consume.
   task automatic wait_resp(input int lat, input string name);
      int          n;
      logic [31:0] e;
      n = 0;
      @(negedge clk);
      while (!resp_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      check({name, " latency"}, 32'(n), 32'(lat));
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
      check({name, " data"}, resp_data, e);
      resp_ready = 1'b1;
      @(posedge clk);
      #1 resp_ready = 1'b0;
   endtask

   task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] e, input int lat, input string name);
      issue(f, a, b, e, name);
      wait_resp(lat, name);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog");
   end

   // ---------------- test ----------------
   initial begin
      int n;
      logic [31:0] d0;

      // Hand-derived vectors.
      add_vec(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT, "mulh_min_min");
      add_vec(3'd0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, MUL_LAT, "mul_min_min");
      add_vec(3'd2, 32'h8000_0000, 32'h8000_0000, 32'hC000_0000, MUL_LAT, "mulhsu_min");
      add_vec(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT, "mulhu_max");
      add_vec(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, MUL_LAT, "mul_max");
      add_vec(3'd1, 32'hFFFF_FFFF, 32'd3,         32'hFFFF_FFFF, MUL_LAT, "mulh_m1_3");
      add_vec(3'd3, 32'hFFFF_FFFF, 32'd3,         32'h0000_0002, MUL_LAT, "mulhu_m1_3");
      add_vec(3'd0, 32'd100000,    32'd100000,    32'h540B_E400, MUL_LAT, "mul_1e10");
      add_vec(3'd3, 32'd100000,    32'd100000,    32'h0000_0002, MUL_LAT, "mulhu_1e10");
      add_vec(3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, DIV_LAT, "div_m7_2");
      add_vec(3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, DIV_LAT, "rem_m7_2");
      add_vec(3'd5, 32'd100,       32'd7,         32'd14,        DIV_LAT, "divu_100_7");
      add_vec(3'd7, 32'd100,       32'd7,         32'd2,         DIV_LAT, "remu_100_7");
      add_vec(3'd4, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, DIV_LAT, "div_7_m2");
      add_vec(3'd6, 32'd7,         32'hFFFF_FFFE, 32'd1,         DIV_LAT, "rem_7_m2");
      add_vec(3'd5, 32'hFFFF_FFFF, 32'd10,        32'h1999_9999, DIV_LAT, "divu_max_10");
      add_vec(3'd7, 32'hFFFF_FFFF, 32'd10,        32'd5,         DIV_LAT, "remu_max_10");
      add_vec(3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, 0,       "divu_by0");
      add_vec(3'd6, 32'd5,         32'd0,         32'd5,         0,       "rem_by0");
      add_vec(3'd4, 32'd5,         32'd0,         32'hFFFF_FFFF, 0,       "div_by0");
      add_vec(3'd7, 32'd5,         32'd0,         32'd5,         0,       "remu_by0");
      add_vec(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0,       "div_ovf");
      add_vec(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         0,       "rem_ovf");
      add_vec(3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         DIV_LAT, "divu_min_max");
      add_vec(3'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, DIV_LAT, "remu_min_max");
      add_vec(3'd4, 32'h8000_0000, 32'd2,         32'hC000_0000, DIV_LAT, "div_min_2");
      add_vec(3'd6, 32'h8000_0000, 32'd2,         32'd0,         DIV_LAT, "rem_min_2");

      // Reset state.
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst req_ready", 32'(req_ready), 32'd0);
      check("rst busy", 32'(busy), 32'd0);
      check("rst resp_valid", 32'(resp_valid), 32'd0);
      check("rst resp_data", resp_data, 32'd0);
      rst = 1'b0;

      // Table-driven vectors.
      foreach (vecs[i]) do_op(vecs[i].func, vecs[i].rs1, vecs[i].rs2, vecs[i].exp, vecs[i].lat, vecs[i].name);

      // Random ops against the reference model.
      for (int i = 0; i < 16; i++) begin
         logic [2:0]  f;
         logic [31:0] a, b;
         f = 3'($urandom_range(0, 7));
         a = $urandom();
         case ($urandom_range(0, 3))
            0:       b = 32'($urandom_range(0, 15));
            default: b = $urandom();
         endcase
         do_op(f, a, b, model(f, a, b), model_lat(f, a, b), "rand");
      end

      // Consumer stalls 10 cycles: response must hold.
      issue(3'd5, 32'd100, 32'd7, 32'd14, "stall");
      n = 0;
      @(negedge clk);
      while (!resp_valid && n < 100) begin @(negedge clk); n++; end
      check("stall latency", 32'(n), 32'(DIV_LAT));
      d0 = resp_data;
      for (int c = 0; c < 10; c++) begin
         check("stall resp_valid", 32'(resp_valid), 32'd1);
         check("stall resp_data", resp_data, 32'd14);
         check("stall busy", 32'(busy), 32'd1);
         check("stall req_ready", 32'(req_ready), 32'd0);
         @(negedge clk);
      end
      check("stall hold", resp_data, d0);
      check("stall data", resp_data, exp_q.pop_front());
      resp_ready = 1'b1;
      @(posedge clk);
      #1 resp_ready = 1'b0;
      @(negedge clk);
      check("stall idle busy", 32'(busy), 32'd0);

      // Flush at E0+10 of a DIV.
      issue(3'd4, 32'd1000, 32'd3, 32'd333, "flush_div");
      void'(exp_q.pop_back());
      repeat (9) @(posedge clk);
      @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      check("flush busy", 32'(busy), 32'd0);
      check("flush resp_valid", 32'(resp_valid), 32'd0);
      n = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (resp_valid || busy) n++;
      end
      check("flush quiet", 32'(n), 32'd0);

      // Flush with req_valid in IDLE: no accept.
      @(negedge clk);
      req_func = 3'd0; req_rs1 = 32'd3; req_rs2 = 32'd4; req_valid = 1'b1; flush = 1'b1;
      #1 check("flush idle req_ready", 32'(req_ready), 32'd0);
      @(posedge clk);
      #1 begin flush = 1'b0; req_valid = 1'b0; end
      check("flush idle busy", 32'(busy), 32'd0);
      do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT, "post_flush_mulhu");

      // Flush together with resp_ready in DONE.
      issue(3'd0, 32'd6, 32'd7, 32'd42, "flush_done");
      void'(exp_q.pop_back());
      n = 0;
      @(negedge clk);
      while (!resp_valid && n < 100) begin @(negedge clk); n++; end
      check("flush_done latency", 32'(n), 32'(MUL_LAT));
      flush = 1'b1; resp_ready = 1'b1;
      @(posedge clk);
      #1 begin flush = 1'b0; resp_ready = 1'b0; end
      check("flush_done busy", 32'(busy), 32'd0);
      check("flush_done resp_valid", 32'(resp_valid), 32'd0);

      // rst mid-DIV with req_valid held.
      issue(3'd5, 32'd1000, 32'd3, 32'd333, "rst_div");
      void'(exp_q.pop_back());
      repeat (5) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      req_func = 3'd0; req_rs1 = 32'd6; req_rs2 = 32'd7; req_valid = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("rst mid busy", 32'(busy), 32'd0);
         check("rst mid resp_valid", 32'(resp_valid), 32'd0);
         check("rst mid resp_data", resp_data, 32'd0);
         check("rst mid req_ready", 32'(req_ready), 32'd0);
      end
      rst = 1'b0;
      #1 check("rst release req_ready", 32'(req_ready), 32'd1);
      @(posedge clk);
      exp_q.push_back(32'd42);
      #1 req_valid = 1'b0;
      wait_resp(MUL_LAT, "post_rst_mul");

      check("scoreboard empty", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
